// File: rtl/glue_cycle_ctrl_if.sv
// CPU-side bus bundle between the 68000 pins, memmap decode and the cycle controller.
// The controller side uses the slave modport; the CPU/decode side uses master.
interface glue_cycle_ctrl_if #(
   parameter int unsigned NUM_CS = 4,
   parameter int unsigned WAIT_W = 4
);
   logic                       as_n;
   logic [2:0]                 fc;
   logic [NUM_CS-1:0]          cs;
   logic                       csunmap;
   logic [NUM_CS*WAIT_W-1:0]   wait_cfg;
   logic                       ext_rdy;
   logic                       dtack_n;
   logic                       berr_n;
   logic                       avec_n;

   modport master (
      output as_n, fc, cs, csunmap, wait_cfg, ext_rdy,
      input  dtack_n, berr_n, avec_n
   );

   modport slave (
      input  as_n, fc, cs, csunmap, wait_cfg, ext_rdy,
      output dtack_n, berr_n, avec_n
   );
endinterface

// File: rtl/glue_cycle_ctrl.sv
// 68000 bus-cycle controller: cpuclk divider, reset/halt stretch, DTACK/BERR termination.
// Optional interrupt-acknowledge autovectoring is enabled with `define GLUE_AVEC_EN.
module glue_cycle_ctrl #(
   parameter int unsigned CLK_DIV      = 8,
   parameter int unsigned RESET_CYCLES = 65535,
   parameter int unsigned NUM_CS       = 4,
   parameter int unsigned WAIT_W       = 4,
   parameter int unsigned BERR_TIMEOUT = 1024
) (
   input  logic               sysclk,
   input  logic               sysrst,
   output logic               cpuclk,
   output logic               cpurst_n,
   output logic               halt_n,
   output logic               cycle_busy,
   glue_cycle_ctrl_if.slave   bus
);

   localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HALF  = CLK_DIV / 2;
   localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);
   localparam int unsigned TMO_W = $clog2(BERR_TIMEOUT);

`ifdef GLUE_AVEC_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_ACK  = 3'd2,
      ST_ERR  = 3'd3,
      ST_AVEC = 3'd4
   } state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_ACK  = 3'd2,
      ST_ERR  = 3'd3
   } state_e;
`endif

   logic [DIV_W-1:0]  div_cnt_q,   div_cnt_d;
   logic              cpuclk_q,    cpuclk_d;
   logic [RST_W-1:0]  rst_cnt_q,   rst_cnt_d;
   logic              cpurst_n_q,  cpurst_n_d;
   logic              as_m_q,      as_m_d;
   logic              as_s_q,      as_s_d;
   state_e            state_q,     state_d;
   logic [WAIT_W-1:0] wcnt_q,      wcnt_d;
   logic [TMO_W-1:0]  tcnt_q,      tcnt_d;
   logic              dtack_n_q,   dtack_n_d;
   logic              berr_n_q,    berr_n_d;
   logic              busy_q,      busy_d;
   logic              cpu_rise_c;
   logic              cs_any_c;
   logic [WAIT_W-1:0] sel_wait_c;

`ifdef GLUE_AVEC_EN
   logic              avec_n_q,    avec_n_d;
`else
   logic              fc_unused_c;
   assign fc_unused_c = ^bus.fc;
`endif

   // Clock divider and reset stretch; the stretch counter saturates at RESET_CYCLES.
   always_comb begin
      div_cnt_d  = (div_cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
      cpuclk_d   = (div_cnt_d >= DIV_W'(HALF));
      cpu_rise_c = (div_cnt_q == DIV_W'(HALF - 1));
      rst_cnt_d  = rst_cnt_q;
      cpurst_n_d = cpurst_n_q;
      if (cpu_rise_c && (rst_cnt_q != RST_W'(RESET_CYCLES))) begin
         rst_cnt_d = rst_cnt_q + RST_W'(1);
      end
      if (rst_cnt_d == RST_W'(RESET_CYCLES)) begin
         cpurst_n_d = 1'b1;
      end
   end

   // Two-flop synchroniser; as_s is the active-high strobe seen by the FSM.
   always_comb begin
      as_m_d = ~bus.as_n;
      as_s_d = as_m_q;
   end

   // Lowest-index chip select wins, so scan from the top down.
   always_comb begin
      cs_any_c   = |bus.cs;
      sel_wait_c = '0;
      for (int i = int'(NUM_CS) - 1; i >= 0; i--) begin
         if (bus.cs[i]) begin
            sel_wait_c = bus.wait_cfg[i*WAIT_W +: WAIT_W];
         end
      end
   end

   // Cycle FSM next-state and registered strobes.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      tcnt_d    = tcnt_q;
      dtack_n_d = dtack_n_q;
      berr_n_d  = berr_n_q;
`ifdef GLUE_AVEC_EN
      avec_n_d  = avec_n_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cpurst_n_q && as_s_q) begin
`ifdef GLUE_AVEC_EN
               if (bus.fc == 3'b111) begin
                  state_d  = ST_AVEC;
                  avec_n_d = 1'b0;
               end else
`endif
               if (bus.csunmap || !cs_any_c) begin
                  state_d  = ST_ERR;
                  berr_n_d = 1'b0;
               end else begin
                  state_d = ST_WAIT;
                  wcnt_d  = sel_wait_c;
                  tcnt_d  = '0;
               end
            end
         end
         ST_WAIT: begin
            if (!as_s_q) begin
               state_d = ST_IDLE;
            end else if (tcnt_q == TMO_W'(BERR_TIMEOUT - 1)) begin
               state_d  = ST_ERR;
               berr_n_d = 1'b0;
            end else if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - WAIT_W'(1);
               tcnt_d = tcnt_q + TMO_W'(1);
            end else if (bus.ext_rdy) begin
               state_d   = ST_ACK;
               dtack_n_d = 1'b0;
            end else begin
               tcnt_d = tcnt_q + TMO_W'(1);
            end
         end
         ST_ACK: begin
            if (!as_s_q) begin
               state_d   = ST_IDLE;
               dtack_n_d = 1'b1;
            end
         end
         ST_ERR: begin
            if (!as_s_q) begin
               state_d  = ST_IDLE;
               berr_n_d = 1'b1;
            end
         end
`ifdef GLUE_AVEC_EN
         ST_AVEC: begin
            if (!as_s_q) begin
               state_d  = ST_IDLE;
               avec_n_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sysclk) begin
      if (sysrst) begin
         div_cnt_q  <= '0;
         cpuclk_q   <= 1'b0;
         rst_cnt_q  <= '0;
         cpurst_n_q <= 1'b0;
         as_m_q     <= 1'b0;
         as_s_q     <= 1'b0;
         state_q    <= ST_IDLE;
         wcnt_q     <= '0;
         tcnt_q     <= '0;
         dtack_n_q  <= 1'b1;
         berr_n_q   <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         cpuclk_q   <= cpuclk_d;
         rst_cnt_q  <= rst_cnt_d;
         cpurst_n_q <= cpurst_n_d;
         as_m_q     <= as_m_d;
         as_s_q     <= as_s_d;
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         tcnt_q     <= tcnt_d;
         dtack_n_q  <= dtack_n_d;
         berr_n_q   <= berr_n_d;
         busy_q     <= busy_d;
      end
   end

`ifdef GLUE_AVEC_EN
   always_ff @(posedge sysclk) begin
      if (sysrst) begin
         avec_n_q <= 1'b1;
      end else begin
         avec_n_q <= avec_n_d;
      end
   end
   assign bus.avec_n = avec_n_q;
`else
   assign bus.avec_n = 1'b1;
`endif

   assign cpuclk      = cpuclk_q;
   assign cpurst_n    = cpurst_n_q;
   assign halt_n      = cpurst_n_q;
   assign cycle_busy  = busy_q;
   assign bus.dtack_n = dtack_n_q;
   assign bus.berr_n  = berr_n_q;

endmodule
